// File: rtl/board_empty_scanner_pkg.sv
// -----------------------------------------------------------------------------
// board_scan_pkg
// Shared types and constants for the board empty-cell scanner.
//   scan_mode_t  : FIRST (stop at first empty) / COUNT (visit every cell)
//   scan_state_t : scanner FSM states
//   CELL_EMPTY_LO/HI : default 4-bit cell codes that mean "empty"
// -----------------------------------------------------------------------------
package board_scan_pkg;

    typedef enum logic {
        MODE_FIRST = 1'b0,
        MODE_COUNT = 1'b1
    } scan_mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_t;

    localparam logic [3:0] CELL_EMPTY_LO = 4'b0000;
    localparam logic [3:0] CELL_EMPTY_HI = 4'b1111;

endpackage

// File: rtl/board_empty_scanner_if.sv
// -----------------------------------------------------------------------------
// board_empty_scanner_if
// Request/result bundle between the requester (move-selection FSM side) and
// the board empty-cell scanner.
//   cells       : flattened board, cell i = cells[i*CELL_W +: CELL_W]
//   start       : scan request, taken only while ready=1
//   start_idx   : first cell to examine (>= N_CELLS is treated as 0)
//   mode        : 0 = FIRST, 1 = COUNT, sampled with start
//   ready       : scanner idle
//   done        : one-cycle pulse when results are valid
//   found       : at least one empty cell seen
//   idx         : first empty index in scan order
//   empty_count : number of empty cells (COUNT mode)
// Modports: master = requester, slave = scanner.
// -----------------------------------------------------------------------------
interface board_empty_scanner_if #(
    parameter int N_CELLS = 16,
    parameter int CELL_W  = 4
);
    localparam int IDX_W = $clog2(N_CELLS);
    localparam int CNT_W = $clog2(N_CELLS + 1);

    logic [N_CELLS*CELL_W-1:0] cells;
    logic                      start;
    logic [IDX_W-1:0]          start_idx;
    logic                      mode;
    logic                      ready;
    logic                      done;
    logic                      found;
    logic [IDX_W-1:0]          idx;
    logic [CNT_W-1:0]          empty_count;

    modport master (
        output cells, start, start_idx, mode,
        input  ready, done, found, idx, empty_count
    );

    modport slave (
        input  cells, start, start_idx, mode,
        output ready, done, found, idx, empty_count
    );

endinterface

// File: rtl/board_empty_scanner_classify.sv
// -----------------------------------------------------------------------------
// cell_empty_classify
// Combinational test of one cell code against the two "empty" codes.
//   i_cell     : cell code
//   o_is_empty : 1 when i_cell equals EMPTY_A or EMPTY_B
// -----------------------------------------------------------------------------
module cell_empty_classify #(
    parameter int                CELL_W  = 4,
    parameter logic [CELL_W-1:0] EMPTY_A = {CELL_W{1'b0}},
    parameter logic [CELL_W-1:0] EMPTY_B = {CELL_W{1'b1}}
) (
    input  logic [CELL_W-1:0] i_cell,
    output logic              o_is_empty
);

    assign o_is_empty = (i_cell == EMPTY_A) || (i_cell == EMPTY_B);

endmodule

// File: rtl/board_empty_scanner.sv
// -----------------------------------------------------------------------------
// board_empty_scanner
// Walks the board one cell per clock starting at a requested index, wrapping
// N_CELLS-1 -> 0, and reports the first empty cell and/or the empty count.
//   i_clk : clock, all state changes on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : board_empty_scanner_if.slave (request in, registered results out)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready=1, waiting for start; results from last scan held
// S_SCAN | examining cell r_cur = (start_idx + r_offset) mod N_CELLS
// S_DONE | done=1 for one cycle, results valid
// -----------------------------------------------------------------------------
module board_empty_scanner
    import board_scan_pkg::*;
#(
    parameter int                N_CELLS = 16,
    parameter int                CELL_W  = 4,
    parameter logic [CELL_W-1:0] EMPTY_A = {CELL_W{1'b0}},
    parameter logic [CELL_W-1:0] EMPTY_B = {CELL_W{1'b1}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    board_empty_scanner_if.slave  bus
);

    localparam int IDX_W = $clog2(N_CELLS);
    localparam int CNT_W = $clog2(N_CELLS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    scan_mode_t       r_mode;
    logic [IDX_W-1:0] r_start_idx;
    logic [IDX_W-1:0] r_cur;
    logic [IDX_W-1:0] r_offset;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_count;
    logic             r_found;
    logic             r_ready;
    logic             r_done;

    logic [IDX_W-1:0]  w_start_clamped;
    logic [IDX_W-1:0]  w_cur_nxt;
    logic [CELL_W-1:0] w_cell;
    logic              w_is_empty;
    logic              w_last;

    // When N_CELLS fills the index range no out-of-range value exists, so the
    // compare is dropped rather than left as a constant-false term.
    generate
        if (N_CELLS == (1 << IDX_W)) begin : g_no_clamp
            assign w_start_clamped = bus.start_idx;
        end else begin : g_clamp
            assign w_start_clamped = (bus.start_idx > LAST_IDX) ? '0 : bus.start_idx;
        end
    endgenerate

    // Cell mux driven by the running index; kept as a compare-per-cell so the
    // unused upper index codes for non-power-of-two boards select nothing.
    always_comb begin
        w_cell = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (r_cur == IDX_W'(i)) begin
                w_cell = bus.cells[i*CELL_W +: CELL_W];
            end
        end
    end

    cell_empty_classify #(
        .CELL_W  (CELL_W),
        .EMPTY_A (EMPTY_A),
        .EMPTY_B (EMPTY_B)
    ) u_classify (
        .i_cell     (w_cell),
        .o_is_empty (w_is_empty)
    );

    // The running index wraps explicitly, so no modulo is needed for
    // non-power-of-two boards.
    assign w_cur_nxt = (r_cur == LAST_IDX) ? '0 : r_cur + 1'b1;
    assign w_last    = (r_offset == LAST_IDX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if ((r_mode == MODE_FIRST && w_is_empty) || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ready/done are registered from the next state so they line up with the
    // state they describe without any output decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode      <= MODE_FIRST;
            r_start_idx <= '0;
            r_cur       <= '0;
            r_offset    <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_found     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode      <= scan_mode_t'(bus.mode);
                        r_start_idx <= w_start_clamped;
                        r_cur       <= w_start_clamped;
                        r_offset    <= '0;
                        r_idx       <= '0;
                        r_count     <= '0;
                        r_found     <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_offset <= r_offset + 1'b1;
                    r_cur    <= w_cur_nxt;
                    if (w_is_empty) begin
                        if (r_mode == MODE_COUNT) begin
                            r_count <= r_count + 1'b1;
                        end
                        // idx keeps only the first hit in scan order
                        if (!r_found) begin
                            r_found <= 1'b1;
                            r_idx   <= r_cur;
                        end
                    end else if (r_mode == MODE_FIRST && w_last) begin
                        // full board in FIRST mode reports the start position
                        r_idx <= r_start_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready       = r_ready;
    assign bus.done        = r_done;
    assign bus.found       = r_found;
    assign bus.idx         = r_idx;
    assign bus.empty_count = r_count;

endmodule

// File: tb/tb_board_empty_scanner.sv
module tb_board_empty_scanner;

    logic clk;
    logic rst;

    board_empty_scanner_if #(.N_CELLS(16), .CELL_W(4)) ifa ();
    board_empty_scanner_if #(.N_CELLS(9),  .CELL_W(4)) ifb ();

    board_empty_scanner #(.N_CELLS(16), .CELL_W(4)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa.slave)
    );

    board_empty_scanner #(.N_CELLS(9), .CELL_W(4)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         lat;
        logic       found;
        logic [3:0] idx;
        logic [4:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference scan: independent walk using modulo indexing.
    function automatic exp_t model(input string tag, input logic [63:0] b, input int n,
                                   input int sidx, input logic mode);
        exp_t       e;
        int         s;
        int         c;
        logic [3:0] v;
        s       = (sidx >= n) ? 0 : sidx;
        e.tag   = tag;
        e.found = 1'b0;
        e.idx   = 4'd0;
        e.cnt   = 5'd0;
        e.lat   = n + 1;
        for (int k = 0; k < n; k++) begin
            c = (s + k) % n;
            v = b[c*4 +: 4];
            if (v == 4'h0 || v == 4'hF) begin
                if (mode) e.cnt = e.cnt + 5'd1;
                if (!e.found) begin
                    e.found = 1'b1;
                    e.idx   = 4'(c);
                    if (!mode) begin
                        e.lat = k + 2;
                        break;
                    end
                end
            end
        end
        if (!mode && !e.found) e.idx = 4'(s);
        return e;
    endfunction

    task automatic snap(input int sel, output logic [31:0] rdy, output logic [31:0] dn,
                        output logic [31:0] fnd, output logic [31:0] ix, output logic [31:0] cn);
        if (sel == 0) begin
            rdy = 32'(ifa.ready); dn = 32'(ifa.done); fnd = 32'(ifa.found);
            ix  = 32'(ifa.idx);   cn = 32'(ifa.empty_count);
        end else begin
            rdy = 32'(ifb.ready); dn = 32'(ifb.done); fnd = 32'(ifb.found);
            ix  = 32'(ifb.idx);   cn = 32'(ifb.empty_count);
        end
    endtask

    task automatic fill_a(input logic [3:0] v);
        for (int i = 0; i < 16; i++) ifa.cells[i*4 +: 4] = v;
    endtask

    task automatic fill_b(input logic [3:0] v);
        for (int i = 0; i < 9; i++) ifb.cells[i*4 +: 4] = v;
    endtask

    // Called at #1 after an edge with the DUT idle; returns at #1 after the
    // accepting edge (first SCAN cycle).
    task automatic launch(input int sel, input int sidx, input logic mode, input string tag);
        if (sel == 0) begin
            ifa.start_idx = 4'(sidx);
            ifa.mode      = mode;
            ifa.start     = 1'b1;
            sb.push_back(model(tag, ifa.cells, 16, sidx, mode));
        end else begin
            ifb.start_idx = 4'(sidx);
            ifb.mode      = mode;
            ifb.start     = 1'b1;
            sb.push_back(model(tag, {28'd0, ifb.cells}, 9, sidx, mode));
        end
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    // Waits (bounded) for done, compares against the scoreboard head, then
    // steps one cycle and checks the idle/hold state. pulse_at > 0 raises a
    // stray start on DUT A during that scan cycle.
    task automatic finish_scan(input int sel, input int pulse_at);
        int          lat;
        exp_t        e;
        logic [31:0] rdy, dn, fnd, ix, cn;
        lat = 1;
        snap(sel, rdy, dn, fnd, ix, cn);
        e = sb.pop_front();
        chk({e.tag, "_busy"}, rdy, 32'd0);
        while (dn !== 32'd1 && lat < 64) begin
            if (lat == pulse_at) begin
                ifa.start_idx = 4'd2;
                ifa.start     = 1'b1;
            end
            @(posedge clk);
            #1;
            ifa.start = 1'b0;
            lat++;
            snap(sel, rdy, dn, fnd, ix, cn);
        end
        chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({e.tag, "_found"},   fnd, 32'(e.found));
        chk({e.tag, "_idx"},     ix,  32'(e.idx));
        chk({e.tag, "_count"},   cn,  32'(e.cnt));
        @(posedge clk);
        #1;
        snap(sel, rdy, dn, fnd, ix, cn);
        chk({e.tag, "_done_pulse"}, dn,  32'd0);
        chk({e.tag, "_ready_back"}, rdy, 32'd1);
        chk({e.tag, "_idx_hold"},   ix,  32'(e.idx));
    endtask

    task automatic check_reset(input int sel, input string tag);
        logic [31:0] rdy, dn, fnd, ix, cn;
        snap(sel, rdy, dn, fnd, ix, cn);
        chk({tag, "_ready"}, rdy, 32'd1);
        chk({tag, "_done"},  dn,  32'd0);
        chk({tag, "_found"}, fnd, 32'd0);
        chk({tag, "_idx"},   ix,  32'd0);
        chk({tag, "_count"}, cn,  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        exp_t e_drop;
        int   n_done;

        rst           = 1'b1;
        ifa.start     = 1'b0;
        ifa.start_idx = '0;
        ifa.mode      = 1'b0;
        ifb.start     = 1'b0;
        ifb.start_idx = '0;
        ifb.mode      = 1'b0;
        fill_a(4'h5);
        fill_b(4'h5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset(0, "por_a");
        check_reset(1, "por_b");

        // FIRST: only cell 3 empty, start 0 -> idx 3, k=3
        fill_a(4'h5);
        ifa.cells[3*4 +: 4] = 4'h0;
        launch(0, 0, 1'b0, "first_c3");
        finish_scan(0, 0);

        // FIRST: hit on the very first cell examined (k=0)
        launch(0, 3, 1'b0, "first_k0");
        finish_scan(0, 0);

        // FIRST with wrap 14,15,0,1
        fill_a(4'h5);
        ifa.cells[1*4 +: 4] = 4'hF;
        launch(0, 14, 1'b0, "first_wrap");
        finish_scan(0, 0);

        // FIRST on a full board
        fill_a(4'h2);
        launch(0, 7, 1'b0, "first_full");
        finish_scan(0, 0);

        // COUNT with a stray start mid-scan
        fill_a(4'h6);
        ifa.cells[0*4 +: 4] = 4'h0;
        ifa.cells[5*4 +: 4] = 4'hF;
        ifa.cells[9*4 +: 4] = 4'h0;
        launch(0, 6, 1'b1, "count3");
        finish_scan(0, 5);

        // Reset in the middle of a scan: no done afterwards
        fill_a(4'h2);
        launch(0, 7, 1'b0, "rst_scan");
        e_drop = sb.pop_front();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset(0, "midscan_rst");
        n_done = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ifa.done === 1'b1) n_done++;
        end
        chk("midscan_rst_no_done", 32'(n_done), 32'd0);

        // N_CELLS=9: out-of-range start clamps to 0, all empty
        for (int i = 0; i < 9; i++) ifb.cells[i*4 +: 4] = (i % 2 == 0) ? 4'h0 : 4'hF;
        launch(1, 12, 1'b1, "n9_count_all");
        finish_scan(1, 0);
        // back-to-back start in the cycle right after done
        launch(1, 4, 1'b0, "n9_b2b");
        finish_scan(1, 0);

        // N_CELLS=9 wrap 8 -> 0: examines 7, 8, 0
        fill_b(4'h3);
        ifb.cells[0*4 +: 4] = 4'hF;
        launch(1, 7, 1'b0, "n9_wrap");
        finish_scan(1, 0);

        // N_CELLS=9 COUNT from 4 over two empties
        ifb.cells[2*4 +: 4] = 4'h0;
        launch(1, 4, 1'b1, "n9_count2");
        finish_scan(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
